// File: rtl/program_counter.sv
// program_counter: holds the current instruction address and sequences branch
// handshakes with the downstream branch stage.
// Optional feature macro: PC_HALT_ON_WRAP_EN. When it is defined, an increment
// from the all-ones address halts the PC until reset instead of wrapping to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | ready=1, accepts sequential or branch steps
// BR_WAIT | branch request outstanding, waiting for br_done or the timeout
// HALT    | PC overflow stop, only with PC_HALT_ON_WRAP_EN; left only by reset
module program_counter #(
    parameter int              SIZE     = 8,
    parameter logic [SIZE-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step,
    input  logic            is_branch,
    input  logic [2:0]      offset,
    output logic            ready,
    output logic [SIZE-1:0] pc,
    output logic            pc_valid,
    output logic            branch_taken,
    output logic            err,
    output logic            halted,
    output logic [SIZE-1:0] br_count,
    output logic [2:0]      br_offset,
    output logic            br_control,
    output logic            br_enable,
    input  logic [SIZE-1:0] br_result,
    input  logic            br_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

`ifdef PC_HALT_ON_WRAP_EN
    typedef enum logic [1:0] {IDLE, BR_WAIT, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, BR_WAIT} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SIZE-1:0] pc_n, count_n;
    logic [2:0]      off_n;
    logic            valid_n, taken_n, err_n, ctl_n, en_n;
    logic            halted_r, halted_n;
    logic            advance;

    assign ready = (state == IDLE);

`ifdef PC_HALT_ON_WRAP_EN
    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    // Next-state and next-register values; a fall-through increment is
    // funnelled through 'advance' so wrap handling lives in one place.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pc_n     = pc;
        valid_n  = 1'b0;
        taken_n  = branch_taken;
        err_n    = err;
        count_n  = br_count;
        off_n    = br_offset;
        ctl_n    = br_control;
        en_n     = br_enable;
        halted_n = halted_r;
        advance  = 1'b0;

        case (state)
            IDLE: begin
                if (step) begin
                    if (is_branch) begin
                        count_n = pc;
                        off_n   = offset;
                        ctl_n   = 1'b1;
                        en_n    = 1'b1;
                        cnt_n   = '0;
                        state_n = BR_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            BR_WAIT: begin
                cnt_n = cnt + CW'(1);
                // First wait cycle ignores br_done: it may be a stale level.
                if ((cnt != '0) && br_done) begin
                    pc_n    = br_result;
                    taken_n = (br_result != pc);
                    valid_n = 1'b1;
                    ctl_n   = 1'b0;
                    en_n    = 1'b0;
                    state_n = IDLE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    err_n   = 1'b1;
                    ctl_n   = 1'b0;
                    en_n    = 1'b0;
                    advance = 1'b1;
                end
            end
            default: begin
                state_n = state;
            end
        endcase

        if (advance) begin
            taken_n = 1'b0;
            state_n = IDLE;
`ifdef PC_HALT_ON_WRAP_EN
            if (&pc) begin
                halted_n = 1'b1;
                state_n  = HALT;
            end else begin
                pc_n    = pc + SIZE'(1);
                valid_n = 1'b1;
            end
`else
            pc_n    = pc + SIZE'(1);
            valid_n = 1'b1;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pc           <= RESET_PC;
            pc_valid     <= 1'b0;
            branch_taken <= 1'b0;
            err          <= 1'b0;
            halted_r     <= 1'b0;
            br_count     <= RESET_PC;
            br_offset    <= 3'b000;
            br_control   <= 1'b0;
            br_enable    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pc           <= pc_n;
            pc_valid     <= valid_n;
            branch_taken <= taken_n;
            err          <= err_n;
            halted_r     <= halted_n;
            br_count     <= count_n;
            br_offset    <= off_n;
            br_control   <= ctl_n;
            br_enable    <= en_n;
        end
    end

endmodule

// File: doc/program_counter.md
# program_counter

Clocked program-counter stage that sits directly upstream of the branch stage. It holds the current instruction address and advances it by one on each sequential step. For branch instructions it drives the branch stage's `currentCount`/`programNum`/`branchControl`/`branchEnable` inputs and waits for `branchDone`. It then loads the returned `branchResult` as the new address, with a timeout fallback if the branch stage never answers.

## Interface
- SIZE, 8, address width in bits; must match the branch stage's SIZE
- RESET_PC, 0, address loaded on reset
- TIMEOUT, 15, maximum number of BR_WAIT cycles before abandoning a branch; must be ≥2

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- step  in  1  request to advance the PC; honoured only while ready=1
- is_branch  in  1  qualifies step; 1 means the instruction is a branch
- offset  in  3  signed branch offset, sampled with step
- ready  out  1  block is in IDLE and will accept step
- pc  out  SIZE  current address
- pc_valid  out  1  one-cycle pulse; pc holds a newly updated value
- branch_taken  out  1  registered; last update came from a branch result different from the old pc
- err  out  1  sticky branch-timeout flag; cleared only by reset
- halted  out  1  PC overflow halt (see Configuration)
- br_count  out  SIZE  to branch stage currentCount; snapshot of pc
- br_offset  out  3  to branch stage programNum
- br_control  out  1  to branch stage branchControl
- br_enable  out  1  to branch stage branchEnable
- br_result  in  SIZE  from branch stage branchResult
- br_done  in  1  from branch stage branchDone; treated as a level signal

## Operation
- Reset values (all outputs, taken at the clock edge where reset=1):
  - pc=RESET_PC, pc_valid=0, branch_taken=0, err=0, halted=0
  - br_enable=0, br_control=0, br_count=RESET_PC, br_offset=0
  - state=IDLE, so ready=1 on the following cycle
- Reset mid-branch: abandons the transaction; br_enable drops on that same edge.
- ready=1 only in state IDLE; step while ready=0 is ignored (not queued).

State IDLE:
- step=1, is_branch=0:
  - pc ← pc+1 (modulo 2^SIZE, see Configuration), pc_valid=1 next cycle, branch_taken ← 0; stay in IDLE.
- step=1, is_branch=1:
  - br_count ← pc, br_offset ← offset, br_control ← 1, br_enable ← 1; wait counter ← 0; go to BR_WAIT.

State BR_WAIT (br_enable=1):
- The counter increments every cycle.
- br_done is qualified only when counter ≥1. This ignores a stale done level left over from a previous transaction on the first cycle.
- Qualified br_done=1:
  - pc ← br_result, branch_taken ← (br_result≠pc), pc_valid pulse; go to IDLE.
  - br_enable and br_control drop on this same edge.
- Counter reaches TIMEOUT with no qualified br_done:
  - err ← 1, pc ← pc+1 (fall-through), branch_taken ← 0, pc_valid pulse; go to IDLE.
- If br_done and the timeout coincide, br_done wins.

Other rules:
- The block never checks br_result; the branch stage returns currentCount itself when an offset would underflow. That case gives branch_taken=0.
- Offset arithmetic lives in the branch stage; this block only passes the 3 bits through.

## Timing
- Sequential step sampled at edge N: pc is new after edge N; pc_valid is high for the cycle N..N+1. Back-to-back steps give one increment per cycle.
- Branch step sampled at edge N:
  - br_enable is high from edge N.
  - The earliest qualified br_done is sampled at edge N+2; pc updates there.
  - ready returns at N+2. Minimum branch latency is 2 cycles; maximum is TIMEOUT+1.
- br_count and br_offset are stable for the whole time br_enable=1.

## Configuration
- PC_HALT_ON_WRAP_EN defined:
  - A sequential increment (or timeout fall-through) from pc = all-ones does not wrap. pc holds, halted ← 1, pc_valid is not pulsed, and the FSM enters HALT.
  - In HALT, ready=0 and all step inputs are ignored until reset.
- PC_HALT_ON_WRAP_EN undefined: pc wraps to 0, halted is tied to 0, and the HALT state does not exist.

## Test plan
- Reset with RESET_PC=0x10, then 3 consecutive sequential steps → pc=0x11,0x12,0x13; pc_valid high for 3 cycles; ready stays 1.
- Branch step at pc=0x20, offset=−3, stub returns 0x1D with br_done 1 cycle after br_enable → br_count=0x20, br_offset=3'b101; pc=0x1D at N+2; branch_taken=1; br_enable low at N+2.
- Branch with stub that never asserts br_done, TIMEOUT=15, pc=0x05 → err=1 and pc=0x06 after 15 wait cycles; steps issued during the wait are ignored.
- br_done held at 1 from the previous branch, new branch issued → not completed on the first BR_WAIT cycle; completes on the second with the stub's new br_result.
- pc=0xFF, sequential step → without the macro pc=0x00 with pc_valid; with PC_HALT_ON_WRAP_EN pc=0xFF, halted=1, ready=0 until reset.
- Reset asserted on the second cycle of BR_WAIT → br_enable=0, pc=RESET_PC, err=0 after that edge; a later br_done is ignored.
